mat_mul_control: RTL and testbench

- Top-level controller plus datapath of an N×N output-stationary systolic array.
- Computes the unsigned matrix product C = A × B from flattened input buses.
- Sequences the skewed feeding of A rows and B columns into a grid of MAC processing elements, then publishes the accumulated results on a registered output bus.
- Sits directly below the matrix-multiply testbench/top; no handshake beyond an enable.

---
 rtl/mat_mul_pkg.sv | 20 ++
 rtl/mat_mul_pe.sv | 39 +++
 rtl/mat_mul_control.sv | 146 ++++++++++++++
 tb/tb_mat_mul_control.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mat_mul_pkg.sv
// Shared definitions for the output-stationary systolic matrix multiplier.
package mat_mul_pkg;

    localparam int unsigned W_DEF = 32;
    localparam int unsigned N_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Element index of [r][c] in a row-major flattened N x N bus.
    function automatic int unsigned elem_off(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/mat_mul_pe.sv
// Systolic MAC element: forwards operands right/down through one register and
// accumulates their product (modulo 2^(2W)) while valid.
module mat_mul_pe #(
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           valid,
    input  logic           clear,
    output logic [W-1:0]   a_out,
    output logic [W-1:0]   b_out,
    output logic [2*W-1:0] acc
);

    logic [2*W-1:0] prod;

    assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clear) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a;
            b_out <= b;
            if (valid) begin
                acc <= acc + prod;
            end
        end
    end

endmodule

// File: rtl/mat_mul_control.sv
// N x N output-stationary systolic multiplier: FSM, step counter, skewed
// operand feed at the array edges and the registered result bus.
module mat_mul_control
    import mat_mul_pkg::*;
#(
    parameter int unsigned W = W_DEF,
    parameter int unsigned N = N_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [W*N*N-1:0]     i_A,
    input  logic [W*N*N-1:0]     i_B,
    output logic [2*W*N*N-1:0]   o_C,
    output logic [W-1:0]         o_d_a00
);

    localparam int unsigned KW   = $clog2(3 * N);
    localparam int unsigned KMAX = 3 * N - 3;

    state_t               state, state_nxt;
    logic                 start;
    logic [KW-1:0]        k;
    logic [W*N*N-1:0]     a_lat, b_lat;
    logic [2*W*N*N-1:0]   acc_flat;

    logic [W-1:0] a_feed [N];
    logic [W-1:0] b_feed [N];
    logic [W-1:0] a_pass [N][N-1];
    logic [W-1:0] b_pass [N-1][N];
    logic [W-1:0] unused_a_edge [N];
    logic [W-1:0] unused_b_edge [N];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (i_en) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            RUN: begin
                if (k == KW'(KMAX)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            k     <= '0;
            a_lat <= '0;
            b_lat <= '0;
            o_C   <= '0;
        end else begin
            if (start) begin
                k     <= '0;
                a_lat <= i_A;
                b_lat <= i_B;
            end else if (state == RUN) begin
                k <= k + KW'(1);
            end
            if (state == DONE) begin
                o_C <= acc_flat;
            end
        end
    end

    // Row i enters A[i][k-i] and column j enters B[k-j][j]; the per-PE
    // register chain supplies the remaining i+j skew.
    for (genvar gi = 0; gi < N; gi++) begin : g_feed
        always_comb begin
            a_feed[gi] = '0;
            b_feed[gi] = '0;
            if (state == RUN) begin
                for (int unsigned c = 0; c < N; c++) begin
                    if (k == KW'(gi + c)) begin
                        a_feed[gi] = a_lat[elem_off(gi, c, N) * W +: W];
                        b_feed[gi] = b_lat[elem_off(c, gi, N) * W +: W];
                    end
                end
            end
        end
    end

    assign o_d_a00 = a_feed[0];

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [W-1:0]  a_in, b_in, a_o, b_o;
            logic [KW-1:0] t;
            logic          valid;

            // Unsigned wrap makes k < i+j land far above N, so one compare covers both bounds.
            assign t     = k - KW'(gi + gj);
            assign valid = (state == RUN) && (t < KW'(N));

            if (gj == 0) begin : g_a_edge
                assign a_in = a_feed[gi];
            end else begin : g_a_inner
                assign a_in = a_pass[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_in = b_feed[gj];
            end else begin : g_b_inner
                assign b_in = b_pass[gi-1][gj];
            end
            if (gj < N - 1) begin : g_a_fwd
                assign a_pass[gi][gj] = a_o;
            end else begin : g_a_end
                assign unused_a_edge[gi] = a_o;
            end
            if (gi < N - 1) begin : g_b_fwd
                assign b_pass[gi][gj] = b_o;
            end else begin : g_b_end
                assign unused_b_edge[gj] = b_o;
            end

            mat_mul_pe #(.W(W)) u_pe (
                .clk   (i_clk),
                .rst_n (i_rst),
                .a     (a_in),
                .b     (b_in),
                .valid (valid),
                .clear (start),
                .a_out (a_o),
                .b_out (b_o),
                .acc   (acc_flat[elem_off(gi, gj, N) * 2 * W +: 2 * W])
            );
        end
    end

endmodule

// File: tb/tb_mat_mul_control.sv
// Directed self-checking bench for mat_mul_control (W=32, N=3).
module tb_mat_mul_control;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 3;
    localparam int unsigned AW = W * N * N;
    localparam int unsigned CW = 2 * W * N * N;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_en;
    logic [AW-1:0] i_A, i_B;
    logic [CW-1:0] o_C;
    logic [W-1:0]  o_d_a00;

    int checks = 0;
    int errors = 0;

    mat_mul_control #(.W(W), .N(N)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_A     (i_A),
        .i_B     (i_B),
        .o_C     (o_C),
        .o_d_a00 (o_d_a00)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] pack_ab(input logic [W-1:0] v [9]);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[i*W +: W] = v[i];
        return r;
    endfunction

    function automatic logic [CW-1:0] pack_c(input logic [2*W-1:0] v [9]);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[i*2*W +: 2*W] = v[i];
        return r;
    endfunction

    logic [W-1:0]   m_ones [9];
    logic [W-1:0]   m_id   [9];
    logic [W-1:0]   m_seq  [9];
    logic [W-1:0]   m_2id  [9];
    logic [W-1:0]   m_one1 [9];
    logic [2*W-1:0] c_v    [9];
    logic [CW-1:0]  c_ones, c_id, c_sq, c_2id, c_rows;

    initial begin
        m_ones = '{9{32'hFFFF_FFFF}};
        m_id   = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        m_seq  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        m_2id  = '{2, 0, 0, 0, 2, 0, 0, 0, 2};
        m_one1 = '{9{32'd1}};
        c_v    = '{9{64'hFFFF_FFFA_0000_0003}};
        c_ones = pack_c(c_v);
        c_v    = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        c_id   = pack_c(c_v);
        c_v    = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
        c_sq   = pack_c(c_v);
        c_v    = '{2, 4, 6, 8, 10, 12, 14, 16, 18};
        c_2id  = pack_c(c_v);
        c_v    = '{6, 6, 6, 15, 15, 15, 24, 24, 24};
        c_rows = pack_c(c_v);

        // Reset held with enable high: nothing may move.
        i_rst = 1'b0;
        i_en  = 1'b1;
        i_A   = pack_ab(m_ones);
        i_B   = pack_ab(m_ones);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("rst_c", o_C, '0);
            chk("rst_a00", CW'(o_d_a00), '0);
        end

        // All-ones, enable kept high so it recomputes continuously.
        i_rst = 1'b1;
        tick(1);
        chk("ones_a00_k0", CW'(o_d_a00), CW'(32'hFFFF_FFFF));
        tick(7);
        chk("ones_edge8", o_C, '0);
        tick(1);
        chk("ones_edge9", o_C, c_ones);
        tick(340);
        chk("ones_hold350", o_C, c_ones);
        i_en = 1'b0;
        tick(20);
        chk("ones_idle", o_C, c_ones);

        // Identity x seq; A changed mid-run must be ignored.
        i_A  = pack_ab(m_id);
        i_B  = pack_ab(m_seq);
        i_en = 1'b1;
        tick(1);
        i_en = 1'b0;
        tick(2);
        i_A = pack_ab(m_ones);
        tick(5);
        chk("id_edge8_hold", o_C, c_ones);
        tick(1);
        chk("id_result", o_C, c_id);

        // seq x seq with a00 debug trace; enable stays high for the re-run.
        i_A  = pack_ab(m_seq);
        i_B  = pack_ab(m_seq);
        i_en = 1'b1;
        tick(1);
        chk("sq_a00_k0", CW'(o_d_a00), CW'(1));
        tick(1);
        chk("sq_a00_k1", CW'(o_d_a00), CW'(2));
        tick(1);
        chk("sq_a00_k2", CW'(o_d_a00), CW'(3));
        tick(1);
        chk("sq_a00_k3", CW'(o_d_a00), '0);
        tick(4);
        chk("sq_edge8_hold", o_C, c_id);
        tick(1);
        chk("sq_result", o_C, c_sq);

        // Re-run: new inputs after DONE, enable still high.
        i_A = pack_ab(m_2id);
        tick(1);
        i_en = 1'b0;
        tick(7);
        chk("rerun_edge8_hold", o_C, c_sq);
        tick(1);
        chk("rerun_result", o_C, c_2id);

        // Mid-op reset at k=3, then a fresh computation.
        i_A  = pack_ab(m_seq);
        i_B  = pack_ab(m_one1);
        i_en = 1'b1;
        tick(4);
        #2;
        i_rst = 1'b0;
        #1;
        chk("midrst_c", o_C, '0);
        chk("midrst_a00", CW'(o_d_a00), '0);
        i_rst = 1'b1;
        tick(1);
        i_en = 1'b0;
        tick(7);
        chk("fresh_edge8", o_C, '0);
        tick(1);
        chk("fresh_result", o_C, c_rows);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
